demux_1_4_reg: RTL and testbench



---
 rtl/demux_1_4_reg.sv | 147 ++++++++++++++
 tb/tb_demux_1_4_reg.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_4_reg.sv
// -----------------------------------------------------------------------------
// demux_1_4_reg
//
// Registered 1-to-4 stream demultiplexer. One W-bit beat per cycle arrives on
// a valid/ready input and is steered by in_sel into one of four single-entry
// output registers. Each register is held until its own consumer takes it, so
// backpressure on one channel stalls only beats addressed to that channel.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   in_valid            producer offers a beat
//   in_ready            beat is accepted this cycle (combinational)
//   in_data [W-1:0]     beat payload
//   in_sel  [1:0]       destination channel 0..3
//   out_valid [3:0]     bit k: channel k register holds a beat
//   out_ready [3:0]     bit k: consumer k takes the beat this cycle
//   out_data0..3        channel register contents (stale while not valid)
//   cnt0..3 [7:0]       per-channel drain counters, wrap at 255
//                       (only with DEMUX_1_4_REG_CNT_EN defined)
//
// Optional feature macro: DEMUX_1_4_REG_CNT_EN
// -----------------------------------------------------------------------------
module demux_1_4_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data0,
  output logic [W-1:0] out_data1,
  output logic [W-1:0] out_data2,
  output logic [W-1:0] out_data3
`ifdef DEMUX_1_4_REG_CNT_EN
  ,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1,
  output logic [7:0]   cnt2,
  output logic [7:0]   cnt3
`endif
);

  logic [3:0]   valid_r;
  logic [W-1:0] data_r [4];
  logic         sel_busy_s;
  logic         accept_s;
  logic [3:0]   load_s;
  logic [3:0]   drain_s;

  // Selected channel is busy when it is full and its consumer is not taking
  // the beat this cycle; a same-cycle drain frees the slot for a new load.
  always_comb begin
    sel_busy_s = 1'b1;
    case (in_sel)
      2'd0:    sel_busy_s = valid_r[0] & ~out_ready[0];
      2'd1:    sel_busy_s = valid_r[1] & ~out_ready[1];
      2'd2:    sel_busy_s = valid_r[2] & ~out_ready[2];
      2'd3:    sel_busy_s = valid_r[3] & ~out_ready[3];
      default: sel_busy_s = 1'b1;
    endcase
  end

  assign in_ready = ~sel_busy_s;
  assign accept_s = in_valid & ~sel_busy_s;
  assign drain_s  = valid_r & out_ready;

  // One-hot load strobe for the channel receiving the accepted beat.
  always_comb begin
    load_s = 4'b0000;
    if (accept_s) begin
      case (in_sel)
        2'd0:    load_s = 4'b0001;
        2'd1:    load_s = 4'b0010;
        2'd2:    load_s = 4'b0100;
        2'd3:    load_s = 4'b1000;
        default: load_s = 4'b0000;
      endcase
    end else begin
      load_s = 4'b0000;
    end
  end

  // Occupancy flags: a load wins over a drain so that a simultaneous
  // drain-and-load keeps the channel full at one beat per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 4'b0000;
    end else begin
      valid_r <= load_s | (valid_r & ~drain_s);
    end
  end

  // Channel data registers; contents are left untouched when a channel drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        data_r[k] <= {W{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load_s[k]) begin
          data_r[k] <= in_data;
        end else begin
          data_r[k] <= data_r[k];
        end
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data0 = data_r[0];
  assign out_data1 = data_r[1];
  assign out_data2 = data_r[2];
  assign out_data3 = data_r[3];

`ifdef DEMUX_1_4_REG_CNT_EN
  logic [7:0] cnt_r [4];

  // Drain counters, one per channel, wrapping naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain_s[k]) begin
          cnt_r[k] <= cnt_r[k] + 8'd1;
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  assign cnt0 = cnt_r[0];
  assign cnt1 = cnt_r[1];
  assign cnt2 = cnt_r[2];
  assign cnt3 = cnt_r[3];
`endif

endmodule

// File: tb/tb_demux_1_4_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1_4_reg
//
// Self-checking bench for demux_1_4_reg. A reference model holds each channel
// as a capacity-one queue of beats plus a drain tally; a table of routing
// vectors, hand-written corner sequences and a random protocol-respecting run
// are compared against it. Counter checks are built when
// DEMUX_1_4_REG_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux_1_4_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_1_4_REG_CNT_EN
  logic [7:0]   cnt0, cnt1, cnt2, cnt3;
`endif

  always #5 clk = ~clk;

  demux_1_4_reg #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3)
`ifdef DEMUX_1_4_REG_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );

  logic [W-1:0] od [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  int nvec = 0;
  int nmis = 0;

  // Reference model: each channel is a queue of at most one beat.
  logic [W-1:0] slot [4][$];
  logic [W-1:0] last_m [4];
  int           drains_m [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      slot[k].delete();
      last_m[k]   = '0;
      drains_m[k] = 0;
    end
  endtask

  function automatic logic model_ready(input logic [1:0] s, input logic [3:0] r);
    return (slot[s].size() == 0) || r[s];
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (slot[k].size() != 0);
    return v;
  endfunction

  // Apply one clock edge to the model: consumers take first, then the accepted
  // beat (judged on the pre-edge state) enters its queue.
  task automatic model_edge(input logic v, input logic [W-1:0] d,
                            input logic [1:0] s, input logic [3:0] r);
    logic rdy;
    rdy = model_ready(s, r);
    for (int k = 0; k < 4; k++) begin
      if (slot[k].size() > 0 && r[k]) begin
        void'(slot[k].pop_front());
        drains_m[k]++;
      end
    end
    if (v && rdy) begin
      slot[s].push_back(d);
      last_m[s] = d;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, model_valid());
    for (int k = 0; k < 4; k++) chk("out_data", od[k], last_m[k]);
`ifdef DEMUX_1_4_REG_CNT_EN
    chk("cnt0", cnt0, 32'(drains_m[0] % 256));
    chk("cnt1", cnt1, 32'(drains_m[1] % 256));
    chk("cnt2", cnt2, 32'(drains_m[2] % 256));
    chk("cnt3", cnt3, 32'(drains_m[3] % 256));
`endif
  endtask

  // One cycle: called 1 time unit after a rising edge, returns the same.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                     input logic [3:0] r, output logic rdy_seen);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = r;
    #1;
    rdy_seen = in_ready;
    chk("in_ready", in_ready, model_ready(s, r));
    model_edge(v, d, s, r);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #1;
    model_reset();
    chk("rst_valid", out_valid, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [1:0]   s;
    logic [3:0]   r;
    logic         exp_rdy;
    logic [3:0]   exp_valid;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic         rdy;
    logic         pv;
    logic [W-1:0] pd;
    logic [1:0]   ps;
    logic [3:0]   pr;
    logic [W-1:0] exp_d;

    tbl[0] = '{1'b1, 4'hA, 2'd0, 4'b0000, 1'b1, 4'b0001};
    tbl[1] = '{1'b1, 4'hB, 2'd1, 4'b0000, 1'b1, 4'b0011};
    tbl[2] = '{1'b1, 4'hC, 2'd2, 4'b0000, 1'b1, 4'b0111};
    tbl[3] = '{1'b1, 4'hD, 2'd3, 4'b0000, 1'b1, 4'b1111};
    tbl[4] = '{1'b1, 4'h5, 2'd2, 4'b0000, 1'b0, 4'b1111};
    tbl[5] = '{1'b1, 4'hE, 2'd2, 4'b0100, 1'b1, 4'b1111};
    tbl[6] = '{1'b0, 4'h0, 2'd3, 4'b1000, 1'b1, 4'b0111};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0; out_ready = 4'b0000;
    model_reset();
    #2;
    chk("reset_valid", out_valid, 32'h0);
    chk("reset_ready", in_ready, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Routing table
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r, rdy);
      chk("tbl_rdy", rdy, tbl[i].exp_rdy);
      chk("tbl_valid", out_valid, tbl[i].exp_valid);
      if (i == 3) begin
        chk("route_d0", out_data0, 32'hA);
        chk("route_d1", out_data1, 32'hB);
        chk("route_d2", out_data2, 32'hC);
        chk("route_d3", out_data3, 32'hD);
      end
    end

    // Full throughput on channel 2 (holds E): consumer sees E,0..9 back to back
    for (int i = 0; i <= 10; i++) begin
      exp_d = (i == 0) ? 4'hE : 4'(i - 1);
      chk("thru_valid2", out_valid[2], 32'h1);
      chk("thru_data2", out_data2, exp_d);
      cyc((i < 10), 4'(i), 2'd2, 4'b0100, rdy);
      if (i < 10) chk("thru_rdy", rdy, 32'h1);
    end
    chk("thru_empty", out_valid, 32'h3);

    // Per-channel backpressure: channel 0 full and stalled, channel 1 flows
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'(i + 1), 2'd1, 4'b0010, rdy);
      chk("bp_rdy1", rdy, 32'h1);
    end
    cyc(1'b1, 4'h7, 2'd0, 4'b0010, rdy);
    chk("bp_stall0", rdy, 32'h0);
    cyc(1'b1, 4'h7, 2'd0, 4'b0010, rdy);
    chk("bp_stall0", rdy, 32'h0);
    cyc(1'b1, 4'h7, 2'd0, 4'b0011, rdy);
    chk("bp_go0", rdy, 32'h1);
    chk("bp_data0", out_data0, 32'h7);

    // Drain on channel 3 while channel 0 loads
    do_reset();
    cyc(1'b1, 4'h9, 2'd3, 4'b0000, rdy);
    chk("xdrain_pre", out_valid, 32'h8);
    cyc(1'b1, 4'h6, 2'd0, 4'b1000, rdy);
    chk("xdrain_post", out_valid, 32'h1);

    // Asynchronous reset with channels 1 and 3 full
    cyc(1'b1, 4'h3, 2'd1, 4'b0001, rdy);
    cyc(1'b1, 4'hC, 2'd3, 4'b0000, rdy);
    chk("arst_pre", out_valid, 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", out_valid, 32'h0);
    for (int k = 0; k < 4; k++) chk("arst_data", od[k], 32'h0);
    in_valid = 1'b0; in_sel = 2'd3; out_ready = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ready", in_ready, 32'h1);
    @(posedge clk);
    #1;

    // Random traffic, holding each offer until accepted
    pv = 1'b0; pd = '0; ps = 2'd0;
    for (int n = 0; n < 400; n++) begin
      if (!pv || rdy) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = 4'($urandom);
        ps = 2'($urandom);
      end
      pr = 4'($urandom);
      cyc(pv, pd, ps, pr, rdy);
    end

`ifdef DEMUX_1_4_REG_CNT_EN
    // 257 drains on channel 1 wrap its counter to 1
    do_reset();
    for (int i = 0; i < 257; i++) cyc(1'b1, 4'(i), 2'd1, 4'b0010, rdy);
    cyc(1'b0, 4'h0, 2'd1, 4'b0010, rdy);
    chk("cnt_wrap1", cnt1, 32'h1);
    chk("cnt_wrap0", cnt0, 32'h0);
    chk("cnt_wrap2", cnt2, 32'h0);
    chk("cnt_wrap3", cnt3, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
